// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: queues host {OP,IN} commands and issues them one at a
// time to the accumulator datapath, capturing results and halting on error.
module calc_cmd_sequencer #(
    parameter int DEPTH = 8,
    parameter int OPW   = 4,
    parameter int INW   = 16,
    parameter int OUTW  = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CMD_VALID,
    output logic            CMD_READY,
    input  logic [OPW-1:0]  CMD_OP,
    input  logic [INW-1:0]  CMD_IN,
    output logic [OPW-1:0]  BB_OP,
    output logic [INW-1:0]  BB_IN,
    input  logic [OUTW-1:0] BB_OUT,
    input  logic [1:0]      BB_ERR,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic [OUTW-1:0] RES_DATA,
    output logic [1:0]      RES_ERR,
    output logic            HALTED,
    input  logic            CLR_HALT,
    output logic [CW-1:0]   COUNT
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [OPW+INW-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               full, empty, push, pop, flush;
    logic [OPW+INW-1:0] cmd_q;
    logic [1:0]         err_q;

    // DZE only counts for Div/Mod, OVF only for Add/Sub.
    function automatic logic [1:0] mask_err(input logic [OPW-1:0] op,
                                            input logic [1:0]     err);
        logic [1:0] m;
        m[0] = err[0] && (op == OPW'(4'b0010) || op == OPW'(4'b0011));
        m[1] = err[1] && (op == OPW'(4'b0101) || op == OPW'(4'b0110));
        return m;
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign CMD_READY = !RST && !full;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = (state == S_IDLE) && !empty && (!RES_VALID || RES_READY);
    assign flush     = (state == S_HALT) && CLR_HALT;
    assign COUNT     = count;
    assign HALTED    = (state == S_HALT);

    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {CMD_OP, CMD_IN};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:    state_nxt = S_IDLE;
            S_IDLE:    if (pop) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (err_q != 2'b00) ? S_HALT : S_IDLE;
            S_HALT:    if (CLR_HALT) state_nxt = S_IDLE;
            default:   state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        BB_OP = '0;
        BB_IN = '0;
        if (!RST) begin
            unique case (state)
                S_INIT:  BB_OP = '1;
                S_ISSUE: {BB_OP, BB_IN} = cmd_q;
                default: ;
            endcase
        end
    end

    // Error flags belong to the issue edge, data to the following edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q <= '0;
            err_q <= '0;
        end else begin
            if (pop) cmd_q <= mem[rd_ptr];
            if (state == S_ISSUE) err_q <= mask_err(cmd_q[OPW+INW-1:INW], BB_ERR);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_ERR   <= '0;
        end else if (state == S_CAPTURE) begin
            RES_VALID <= 1'b1;
            RES_DATA  <= BB_OUT;
            RES_ERR   <= err_q;
        end else if (RES_VALID && RES_READY) begin
            RES_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: datapath stand-in, transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_calc_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [3:0]    cmd_op = '0;
    logic [15:0]   cmd_in = '0;
    logic          cmd_ready;
    logic [3:0]    bb_op;
    logic [15:0]   bb_in;
    logic [31:0]   bb_out;
    logic [1:0]    bb_err;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [31:0]   res_data;
    logic [1:0]    res_err;
    logic          halted;
    logic          clr_halt = 1'b0;
    logic [CW-1:0] count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_IN(cmd_in),
        .BB_OP(bb_op), .BB_IN(bb_in), .BB_OUT(bb_out), .BB_ERR(bb_err),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES_DATA(res_data), .RES_ERR(res_err),
        .HALTED(halted), .CLR_HALT(clr_halt), .COUNT(count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Datapath stand-in; raw error bits carry junk on ops that must be masked.
    function automatic logic [33:0] dp(input logic [3:0] op, input logic [15:0] in,
                                       input logic [31:0] acc);
        logic [16:0] s;
        logic [31:0] a;
        logic [1:0]  e;
        a = acc;
        e = {in[0], in[1]};
        case (op)
            4'hF: a = '0;
            4'h2: begin
                s = {1'b0, acc[15:0]} + {1'b0, in};
                a = {16'h0, s[15:0]};
                e = {in[2], s[16]};
            end
            4'h3: begin
                s = {1'b0, acc[15:0]} - {1'b0, in};
                a = {16'h0, s[15:0]};
                e = {in[2], s[16]};
            end
            4'h4: a = 32'(acc[15:0]) * 32'(in);
            4'h5: begin
                e = {in == 16'h0, acc[0]};
                if (in != 16'h0) a = acc / 32'(in);
            end
            4'h6: begin
                e = {in == 16'h0, acc[0]};
                if (in != 16'h0) a = acc % 32'(in);
            end
            default: ;
        endcase
        return {e, a};
    endfunction

    // Error that must reach RES_ERR, from the arithmetic meaning of each op.
    function automatic logic [1:0] want_err(input logic [3:0] op, input logic [15:0] in,
                                            input logic [31:0] acc);
        case (op)
            4'h2:       return {1'b0, (32'(acc[15:0]) + 32'(in)) > 32'hFFFF};
            4'h3:       return {1'b0, acc[15:0] < in};
            4'h5, 4'h6: return {in == 16'h0, 1'b0};
            default:    return 2'b00;
        endcase
    endfunction

    logic [31:0] acc = '0;
    logic [33:0] dp_now;
    assign dp_now = dp(bb_op, bb_in, acc);
    assign bb_out = acc;
    assign bb_err = dp_now[33:32];
    always @(posedge clk) acc <= dp_now[31:0];

    // Reference model: command queue, pending result, halt flag.
    logic [19:0] mq[$];
    logic [19:0] cur = '0;
    logic [31:0] macc = '0, m_data = '0, pend_data = '0, last_data = '0;
    logic [1:0]  m_err = '0, pend_err = '0, last_err = '0;
    bit          m_rv, m_halt, issuing, capturing, init_cyc;
    int          n_res = 0;

    always @(negedge clk) begin
        bit pu, po, fl;
        logic [33:0] r;
        if (rst) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_bb_op", bb_op, 0);
            mq.delete();
            m_rv = 0; m_halt = 0; issuing = 0; capturing = 0; init_cyc = 1;
        end else begin
            chk("bb_op", bb_op, init_cyc ? 4'hF : (issuing ? cur[19:16] : 4'h0));
            chk("bb_in", bb_in, issuing ? cur[15:0] : 16'h0);
            chk("res_valid", res_valid, m_rv);
            if (m_rv) begin
                chk("res_data", res_data, m_data);
                chk("res_err", res_err, m_err);
            end
            chk("halted", halted, m_halt);
            chk("count", count, mq.size());
            chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
            if (m_rv && res_ready) begin
                n_res++;
                last_data = res_data;
                last_err = res_err;
            end
            pu = cmd_valid && (mq.size() < DEPTH);
            fl = m_halt && clr_halt;
            po = !init_cyc && !issuing && !capturing && !m_halt &&
                 mq.size() > 0 && (!m_rv || res_ready);
            if (m_rv && res_ready) m_rv = 0;
            if (capturing) begin
                m_rv = 1;
                m_data = pend_data;
                m_err = pend_err;
                m_halt = (pend_err != 2'b00);
            end
            capturing = issuing;
            if (issuing) begin
                pend_err = want_err(cur[19:16], cur[15:0], macc);
                r = dp(cur[19:16], cur[15:0], macc);
                macc = r[31:0];
                pend_data = macc;
            end
            if (init_cyc) macc = '0;
            init_cyc = 0;
            issuing = po;
            if (po) cur = mq.pop_front();
            if (pu && !fl) mq.push_back({cmd_op, cmd_in});
            if (fl) begin
                mq.delete();
                m_halt = 0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] in);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_in = in;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_res(input string nm, output logic [31:0] d, output logic [1:0] e);
        int start;
        bit got;
        start = n_res;
        got = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (n_res != start) got = 1;
        end
        res_ready = 1'b0;
        chk({nm, "_arrive"}, got, 1);
        d = last_data;
        e = last_err;
    endtask

    function automatic logic [3:0] pick_op();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 4'h2;
            4:          return 4'h3;
            5:          return 4'h5;
            6:          return 4'h6;
            7:          return 4'h4;
            8:          return 4'hF;
            default:    return 4'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic [1:0]  e;
        int          start;
        bit          seen;

        // 1: reset and the single INIT cycle
        do_reset();
        @(negedge clk) chk("t1_init_op", bb_op, 4'hF);
        @(negedge clk) chk("t1_idle_op", bb_op, 4'h0);
        chk("t1_res_valid", res_valid, 0);
        chk("t1_count", count, 0);
        @(posedge clk) #1;

        // 2: two adds back to back
        push(4'h2, 16'd5);
        push(4'h2, 16'd7);
        get_res("t2a", d, e);
        chk("t2a_data", d, 32'd5);
        chk("t2a_err", e, 2'b00);
        get_res("t2b", d, e);
        chk("t2b_data", d, 32'd12);
        chk("t2b_err", e, 2'b00);

        // 3: clear then subtract through zero
        push(4'hF, 16'd0);
        push(4'h3, 16'd1);
        get_res("t3a", d, e);
        chk("t3a_data", d, 32'd0);
        get_res("t3b", d, e);
        chk("t3b_data", d, 32'h0000FFFF);
        chk("t3b_err", e, 2'b01);
        chk("t3_halted", halted, 1);
        clr_halt = 1'b1;
        @(posedge clk) #1 clr_halt = 1'b0;
        chk("t3_unhalt", halted, 0);

        // 4: divide by zero halts; the following command waits
        do_reset();
        push(4'h2, 16'd9);
        push(4'h5, 16'd0);
        push(4'h2, 16'd1);
        get_res("t4a", d, e);
        chk("t4a_data", d, 32'd9);
        get_res("t4b", d, e);
        chk("t4b_data", d, 32'd9);
        chk("t4b_err", e, 2'b10);
        repeat (5) @(negedge clk) chk("t4_no_issue", bb_op, 4'h0);
        chk("t4_halted", halted, 1);
        chk("t4_count", count, 1);
        @(posedge clk) #1 clr_halt = 1'b1;
        @(posedge clk) #1 clr_halt = 1'b0;
        @(negedge clk);
        chk("t4_flush", count, 0);
        chk("t4_idle", halted, 0);
        @(posedge clk) #1;

        // 5: result held, FIFO fills, extra pushes dropped, then drain
        do_reset();
        for (int k = 1; k <= DEPTH + 2; k++) push(4'h2, 16'(k));
        @(negedge clk);
        chk("t5_count_full", count, DEPTH);
        chk("t5_not_ready", cmd_ready, 0);
        chk("t5_held_valid", res_valid, 1);
        chk("t5_held_data", res_data, 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_stable", res_data, 32'd1);
        @(posedge clk) #1;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            get_res("t5_drain", d, e);
            chk("t5_drain_data", d, 32'(k * (k + 1) / 2));
        end
        repeat (6) @(posedge clk);
        #1 chk("t5_empty", count, 0);
        chk("t5_no_extra", res_valid, 0);

        // 6: reset lands during an ISSUE cycle
        push(4'h4, 16'd3);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bb_op == 4'h4) seen = 1;
        end
        chk("t6_issue_seen", seen, 1);
        do_reset();
        @(negedge clk) chk("t6_init_op", bb_op, 4'hF);
        repeat (4) @(negedge clk) chk("t6_no_result", res_valid, 0);
        chk("t6_count", count, 0);
        @(posedge clk) #1;

        // random traffic against the model
        start = n_res;
        for (int c = 0; c < 4000; c++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op = pick_op();
            cmd_in = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            clr_halt = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 599) == 0);
            @(posedge clk) #1;
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        clr_halt = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rand_progress", (n_res - start) > 50, 1);
        chk("final_count", count, 0);
        chk("final_res_valid", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
